// File: rtl/alu_result_stage.sv
// ALU result stage: a 2-entry in-order skid buffer between the ALU and its
// consumer. Each entry holds {result, flags}. The head entry drives the
// output registers directly. The block also keeps the architectural flag
// register and a sticky overflow bit, both of which update when an entry
// is accepted.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_sel,
  input  logic [3:0]       in_flags,
  input  logic             in_flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       flag_reg,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  // Occupancy of the buffer; the encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q;
  occ_e             state_d;

  // Registered ready. It is cleared by reset, so the stage refuses input
  // while reset is held and until the first clock edge after release.
  logic             ready_q;

  // The head entry lives in the output registers. The tail entry is the
  // skid slot, used only when the consumer stalls with one entry queued.
  logic [WIDTH-1:0] head_result_q;
  logic [3:0]       head_flags_q;
  logic [WIDTH-1:0] tail_result_q;
  logic [3:0]       tail_flags_q;

  logic             push;
  logic             pop;
  logic [3:0]       entry_flags;
  logic             head_load_in;
  logic             head_load_tail;
  logic             tail_load_in;
  logic             flag_update;
  logic             ovf_set;

  // Handshake decode. in_ready and out_valid come from registers only, so
  // no path runs from the in_* inputs to any output.
  assign push      = in_valid && ready_q;
  assign pop       = (state_q != EMPTY) && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);

  // Complement results carry no flags, so their stored flags are zero.
  assign entry_flags = in_sel ? 4'b0000 : in_flags;

  // flag_reg follows only flag-writing add operations. Sticky overflow is
  // set by any accepted add that reports overflow, whatever in_flag_we is.
  assign flag_update = push && in_flag_we && !in_sel;
  assign ovf_set     = push && !in_sel && in_flags[3];

  assign out_result = head_result_q;
  assign out_flags  = head_flags_q;

  // Next occupancy and the steering of data into the head and tail slots.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d        = state_q;
    head_load_in   = 1'b0;
    head_load_tail = 1'b0;
    tail_load_in   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d      = ONE;
          head_load_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          // The head leaves as the new word arrives; it takes the head slot
          // directly, which keeps entries in order.
          head_load_in = 1'b1;
        end else if (push) begin
          state_d      = FULL;
          tail_load_in = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d        = ONE;
          head_load_tail = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Occupancy state and the registered ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state is written with non-blocking assignments,
      // so every flop samples the values from before the edge.
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
    end
  end

  // Head entry; this is what the consumer sees on out_result/out_flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_result_q <= '0;
      head_flags_q  <= '0;
    end else if (head_load_in) begin
      head_result_q <= in_result;
      head_flags_q  <= entry_flags;
    end else if (head_load_tail) begin
      head_result_q <= tail_result_q;
      head_flags_q  <= tail_flags_q;
    end
  end

  // Tail (skid) entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data slots are reset as well, even though occupancy alone
      // decides whether they are valid. The head is visible on the outputs
      // and must read zero in reset. Resetting the tail too means a stale
      // word can never reach the head after a reset.
      tail_result_q <= '0;
      tail_flags_q  <= '0;
    end else if (tail_load_in) begin
      tail_result_q <= in_result;
      tail_flags_q  <= entry_flags;
    end
  end

  // Architectural flags, updated when an entry is pushed (not when it pops).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_reg <= 4'b0000;
    end else if (flag_update) begin
      flag_reg <= entry_flags;
    end
  end

  // Sticky overflow. A set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_ovf <= 1'b0;
    end else if (ovf_set) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage. A stimulus process drives inputs 3 time
// units after each rising edge. It keeps a reference model made of an
// ordered queue of expected entries plus the expected flag_reg and
// sticky_ovf values. A separate monitor runs on each falling edge. It
// checks the presented head against the queue front and pops the queue
// when the consumer accepts.
module tb_alu_result_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_sel;
  logic [3:0]       in_flags;
  logic             in_flag_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [3:0]       flag_reg;
  logic             sticky_ovf;
  logic             clr_sticky;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } entry_t;

  // Scoreboard: expected entries, oldest at the front, at most two deep.
  entry_t     sb[$];
  logic [3:0] exp_flag_reg;
  logic       exp_sticky;
  int         n_cmp;
  int         n_bad;

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .in_flags   (in_flags),
    .in_flag_we (in_flag_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .flag_reg   (flag_reg),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, while the inputs are stable.
  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
    if (out_valid && sb.size() != 0) begin
      check("out_result", out_result, sb[0].result);
      check("out_flags", {28'd0, out_flags}, {28'd0, sb[0].flags});
      if (out_ready) void'(sb.pop_front());
    end
  end

  // One clock cycle of stimulus. Call it at posedge+3 and it returns at
  // the next posedge+3.
  task automatic step(input logic v, input logic [WIDTH-1:0] r,
                      input logic sel, input logic [3:0] fl, input logic we,
                      input logic ordy, input logic clr);
    bit     acc;
    entry_t e;
    check("in_ready", {31'd0, in_ready}, {31'd0, (reset_n && sb.size() < 2)});
    in_valid   = v;
    in_result  = r;
    in_sel     = sel;
    in_flags   = fl;
    in_flag_we = we;
    out_ready  = ordy;
    clr_sticky = clr;
    acc = v && reset_n && (sb.size() < 2);
    @(posedge clk);
    if (acc) begin
      e.result = r;
      e.flags  = sel ? 4'b0000 : fl;
      sb.push_back(e);
      if (we && !sel) exp_flag_reg = fl;
    end
    if (acc && !sel && fl[3]) exp_sticky = 1'b1;
    else if (clr)             exp_sticky = 1'b0;
    #3;
    check("flag_reg", {28'd0, flag_reg}, {28'd0, exp_flag_reg});
    check("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, exp_sticky});
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, 1'b0, 4'b0000, 1'b0, ordy, 1'b0);
  endtask

  task automatic push(input logic [WIDTH-1:0] r, input logic sel,
                      input logic [3:0] fl, input logic we, input logic ordy);
    step(1'b1, r, sel, fl, we, ordy, 1'b0);
  endtask

  // Assert reset between clock edges, check its effect at once, and then
  // release it. The input is held valid throughout, and nothing may be
  // accepted.
  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    sb.delete();
    exp_flag_reg = 4'b0000;
    exp_sticky   = 1'b0;
    #1;
    check("rst out_valid", {31'd0, out_valid}, '0);
    check("rst in_ready", {31'd0, in_ready}, '0);
    check("rst out_result", out_result, '0);
    check("rst out_flags", {28'd0, out_flags}, '0);
    check("rst flag_reg", {28'd0, flag_reg}, '0);
    check("rst sticky_ovf", {31'd0, sticky_ovf}, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst hold in_ready", {31'd0, in_ready}, '0);
    #2;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    exp_flag_reg = 4'b0000;
    exp_sticky   = 1'b0;
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_result    = '0;
    in_sel       = 1'b0;
    in_flags     = 4'b0000;
    in_flag_we   = 1'b0;
    out_ready    = 1'b0;
    clr_sticky   = 1'b0;
    @(posedge clk);
    #3;
    do_reset();

    // Single pass-through.
    push(32'h0000_0005, 1'b0, 4'b0000, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure fill; 0x33 arrives while full and is dropped.
    push(32'h11, 1'b0, 4'b0000, 1'b0, 1'b0);
    push(32'h22, 1'b0, 4'b0000, 1'b0, 1'b0);
    push(32'h33, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Simultaneous push and pop while holding one entry.
    push(32'hAA, 1'b0, 4'b0000, 1'b0, 1'b0);
    push(32'hBB, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Flag and sticky rules.
    push(32'h1, 1'b0, 4'b0101, 1'b1, 1'b1);
    push(32'h2, 1'b0, 4'b1000, 1'b0, 1'b1);
    push(32'h3, 1'b1, 4'b1111, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    push(32'h4, 1'b0, 4'b1010, 1'b1, 1'b1);
    step(1'b1, 32'h5, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // Asynchronous reset while full, then a fresh entry.
    push(32'h66, 1'b0, 4'b0011, 1'b1, 1'b0);
    push(32'h77, 1'b0, 4'b1000, 1'b1, 1'b0);
    do_reset();
    push(32'h88, 1'b0, 4'b0001, 1'b0, 1'b1);
    idle(1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), WIDTH'($urandom()),
           1'($urandom_range(0, 3) == 0), 4'($urandom()),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0));
    end

    // Drain everything.
    repeat (4) idle(1'b1);
    check("drained", {31'd0, out_valid}, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
